// File: rtl/axi_progmem_wr_slave.sv
// axi_progmem_wr_slave: AXI4-Lite write-only slave that writes accepted words into a BRAM write port
// Optional feature macro: PROGMEM_WR_COUNT_EN (adds a saturating 32-bit count of legal writes)
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   axi_aw*/axi_w*                AXI4-Lite write address / write data channels
//   b_ready, b_valid, b_response  write response channel (00 OKAY, 10 SLVERR)
//   mem_we/mem_addr/mem_wdata/mem_be  BRAM synchronous write port (word index, data, byte enables)
//   wr_count                      legal-write counter, only with PROGMEM_WR_COUNT_EN
module axi_progmem_wr_slave #(
   parameter int MEM_ADDR_SIZE = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH_WORDS = 4096,
   parameter logic [MEM_ADDR_SIZE-1:0] BASE_ADDR = '0,
   localparam int IDX_W = $clog2(MEM_DEPTH_WORDS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [MEM_ADDR_SIZE-1:0] axi_awaddr,
   input  logic                     axi_awvalid,
   output logic                     axi_awready,
   input  logic [DATA_WIDTH-1:0]    axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]  axi_wstrb,
   input  logic                     axi_wvalid,
   output logic                     axi_wready,
   input  logic                     b_ready,
   output logic                     b_valid,
   output logic [1:0]               b_response,
   output logic                     mem_we,
   output logic [IDX_W-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [DATA_WIDTH/8-1:0]  mem_be
`ifdef PROGMEM_WR_COUNT_EN
   ,output logic [31:0]             wr_count
);
`else
);
`endif
   typedef enum logic [2:0] {INIT, IDLE, WAIT_W, WAIT_AW, WRITE, RESP} state_t;
   state_t r_state, w_next;
   logic r_awready, r_wready, r_bvalid, r_mem_we;
   logic [1:0] r_bresp;
   logic [MEM_ADDR_SIZE-1:0] r_addr, w_addr, w_off;
   logic [DATA_WIDTH-1:0] r_data, w_data, r_mem_wdata;
   logic [DATA_WIDTH/8-1:0] r_strb, w_strb, r_mem_be;
   logic [IDX_W-1:0] r_mem_addr;
   logic w_aw, w_w, w_legal;
   assign axi_awready = r_awready;
   assign axi_wready = r_wready;
   assign b_valid = r_bvalid;
   assign b_response = r_bresp;
   assign mem_we = r_mem_we;
   assign mem_addr = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be = r_mem_be;
   assign w_aw = axi_awvalid && r_awready;
   assign w_w = axi_wvalid && r_wready;
   // Bypass the capture registers so a handshake on the edge entering WRITE is already decoded
   assign w_addr = w_aw ? axi_awaddr : r_addr;
   assign w_data = w_w ? axi_wdata : r_data;
   assign w_strb = w_w ? axi_wstrb : r_strb;
   assign w_off = w_addr - BASE_ADDR;
   assign w_legal = (w_addr >= BASE_ADDR) && (w_off[1:0] == 2'b00) &&
                    ({2'b00, w_off[MEM_ADDR_SIZE-1:2]} < MEM_ADDR_SIZE'(MEM_DEPTH_WORDS));
   always_comb begin
      w_next = r_state;
      case (r_state)
         INIT:    w_next = IDLE;
         IDLE:    w_next = (w_aw && w_w) ? WRITE : w_aw ? WAIT_W : w_w ? WAIT_AW : IDLE;
         WAIT_W:  w_next = w_w ? WRITE : WAIT_W;
         WAIT_AW: w_next = w_aw ? WRITE : WAIT_AW;
         WRITE:   w_next = RESP;
         RESP:    w_next = b_ready ? IDLE : RESP;
         default: w_next = INIT;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= INIT;
      else r_state <= w_next;
   end
   // Handshake and memory outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_awready <= 1'b0;
         r_wready <= 1'b0;
         r_bvalid <= 1'b0;
         r_bresp <= 2'b00;
         r_mem_we <= 1'b0;
         r_mem_addr <= '0;
         r_mem_wdata <= '0;
         r_mem_be <= '0;
         r_addr <= '0;
         r_data <= '0;
         r_strb <= '0;
      end else begin
         r_awready <= (w_next == IDLE) || (w_next == WAIT_AW);
         r_wready <= (w_next == IDLE) || (w_next == WAIT_W);
         r_bvalid <= w_next == RESP;
         r_mem_we <= (w_next == WRITE) && w_legal;
         if (w_aw) r_addr <= axi_awaddr;
         if (w_w) r_data <= axi_wdata;
         if (w_w) r_strb <= axi_wstrb;
         if ((w_next == WRITE) && w_legal) begin
            r_mem_addr <= w_off[IDX_W+1:2];
            r_mem_wdata <= w_data;
            r_mem_be <= w_strb;
         end
         // mem_we is high in WRITE exactly when the captured address was legal
         if (r_state == WRITE) r_bresp <= r_mem_we ? 2'b00 : 2'b10;
      end
   end
`ifdef PROGMEM_WR_COUNT_EN
   logic [31:0] r_wr_count;
   assign wr_count = r_wr_count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_wr_count <= '0;
      else if ((r_state == WRITE) && r_mem_we && (r_wr_count != 32'hFFFF_FFFF)) r_wr_count <= r_wr_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_axi_progmem_wr_slave.sv
// tb_axi_progmem_wr_slave: directed bench with a transaction-level scoreboard for axi_progmem_wr_slave
module tb_axi_progmem_wr_slave;
   localparam logic [31:0] BASE = 32'h0;
   localparam int DEPTH = 4096;
   typedef struct {logic [11:0] idx; logic [31:0] data; logic [3:0] be;} wr_t;
   logic clk = 0, rst = 1;
   logic [31:0] axi_awaddr = 0, axi_wdata = 0;
   logic [3:0] axi_wstrb = 0;
   logic axi_awvalid = 0, axi_wvalid = 0, b_ready = 0;
   logic axi_awready, axi_wready, b_valid, mem_we;
   logic [1:0] b_response;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0] mem_be;
`ifdef PROGMEM_WR_COUNT_EN
   logic [31:0] wr_count;
`endif
   wr_t wq[$];
   logic [1:0] rq[$];
   wr_t e;
   int errors = 0, checks = 0, n_legal = 0;

   axi_progmem_wr_slave dut (
      .clk(clk), .rst(rst),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .b_ready(b_ready), .b_valid(b_valid), .b_response(b_response),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
`ifdef PROGMEM_WR_COUNT_EN
      ,.wr_count(wr_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && (off % 4 == 0) && (off / 4 < DEPTH);
   endfunction

   always @(negedge clk) if (!rst) begin
      if (mem_we) begin
         if (wq.size() == 0) chk("unexpected_mem_we", 1, 0);
         else begin
            e = wq.pop_front();
            chk("mem_addr", mem_addr, e.idx);
            chk("mem_wdata", mem_wdata, e.data);
            chk("mem_be", mem_be, e.be);
         end
      end
      if (b_valid && b_ready) begin
         if (rq.size() == 0) chk("unexpected_b_handshake", 1, 0);
         else chk("b_response", b_response, rq.pop_front());
      end
      if (b_valid) chk("readies_low_while_b_valid", {axi_awready, axi_wready}, 0);
   end

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int gap);
      int t;
      bit awd, wd;
      wr_t x;
      t = 0; awd = 0; wd = 0;
      if (legal(a)) begin
         x.idx = 12'((a - BASE) / 4); x.data = d; x.be = s;
         wq.push_back(x);
         rq.push_back(2'b00);
         n_legal++;
      end else rq.push_back(2'b10);
      while (!(awd && wd) && t < 40) begin
         @(posedge clk); #1;
         axi_awvalid = !awd && (t >= (gap < 0 ? -gap : 0));
         axi_wvalid = !wd && (t >= (gap > 0 ? gap : 0));
         axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
         @(negedge clk);
         if (awd && !wd) chk("awready_low_waiting_w", axi_awready, 0);
         if (wd && !awd) chk("wready_low_waiting_aw", axi_wready, 0);
         awd |= axi_awvalid && axi_awready;
         wd |= axi_wvalid && axi_wready;
         t++;
      end
      if (!(awd && wd)) chk("handshake_timeout", 0, 1);
      @(posedge clk); #1;
      axi_awvalid = 0; axi_wvalid = 0;
   endtask

   task automatic resp(input int bhold);
      int t;
      logic [1:0] r0;
      t = 0;
      while (!b_valid && t < 20) begin @(negedge clk); t++; end
      chk("b_valid_rise", b_valid, 1);
      r0 = b_response;
      for (int i = 0; i < bhold; i++) begin
         chk("bp_b_valid_held", b_valid, 1);
         chk("bp_b_response_stable", b_response, r0);
         @(negedge clk);
      end
      @(posedge clk); #1 b_ready = 1;
      @(posedge clk); #1 b_ready = 0;
      @(negedge clk);
      chk("b_valid_dropped", b_valid, 0);
      chk("idle_readies", {axi_awready, axi_wready}, 2'b11);
`ifdef PROGMEM_WR_COUNT_EN
      chk("wr_count", wr_count, n_legal);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      #12;
      @(negedge clk);
      chk("rst_awready", axi_awready, 0);
      chk("rst_wready", axi_wready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_b_response", b_response, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("init_readies", {axi_awready, axi_wready}, 0);
      @(negedge clk);
      chk("idle_readies_after_init", {axi_awready, axi_wready}, 2'b11);

      send(32'h10, 32'hDEADBEEF, 4'hF, 0);
      @(negedge clk);
      chk("t1_mem_we_n1", mem_we, 1);
      chk("t1_mem_addr", mem_addr, 12'd4);
      chk("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t1_mem_be", mem_be, 4'hF);
      chk("t1_b_valid_n1", b_valid, 0);
      @(negedge clk);
      chk("t1_b_valid_n2", b_valid, 1);
      chk("t1_b_response", b_response, 2'b00);
      chk("t1_mem_we_one_pulse", mem_we, 0);
      chk("t1_mem_wdata_hold", mem_wdata, 32'hDEADBEEF);
      resp(0);

      send(32'h3FFC, 32'h12345678, 4'hF, 3);
      @(negedge clk);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_addr", mem_addr, 12'hFFF);
      resp(0);

      send(32'h4000, 32'h11111111, 4'hF, 0);
      @(negedge clk);
      chk("t3_oor_no_we", mem_we, 0);
      @(negedge clk);
      chk("t3_oor_slverr", b_response, 2'b10);
      resp(0);
      send(32'h11, 32'h22222222, 4'h3, -2);
      @(negedge clk);
      chk("t3_misaligned_no_we", mem_we, 0);
      @(negedge clk);
      chk("t3_misaligned_slverr", b_response, 2'b10);
      resp(0);
      send(32'hFFFF_FFFC, 32'h33333333, 4'hF, 1);
      resp(0);

      send(32'h20, 32'hA5A5_5A5A, 4'h6, 0);
      resp(5);
      send(32'h8, 32'hCAFE_F00D, 4'h0, -1);
      resp(0);

      send(32'h30, 32'h44444444, 4'hF, 0);
      t = 0;
      while (!b_valid && t < 20) begin @(negedge clk); t++; end
      chk("t5_b_valid_before_reset", b_valid, 1);
      #2 rst = 1;
      #1;
      chk("t5_async_b_valid", b_valid, 0);
      chk("t5_async_readies", {axi_awready, axi_wready}, 0);
      if (rq.size() != 0) void'(rq.pop_front());
      n_legal = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("t5_init_readies", {axi_awready, axi_wready}, 0);
      chk("t5_no_mem_we", mem_we, 0);
      @(negedge clk);
      chk("t5_idle_readies", {axi_awready, axi_wready}, 2'b11);
      send(32'h0, 32'h0BAD_CAFE, 4'hF, 0);
      @(negedge clk);
      chk("t5_mem_addr_zero", mem_addr, 12'd0);
      resp(0);
      send(32'h4, 32'h55555555, 4'hC, 2);
      resp(0);
      send(32'h2, 32'h66666666, 4'hF, 0);
      resp(1);
      send(32'hFFC, 32'h77777777, 4'h1, -3);
      resp(0);
`ifdef PROGMEM_WR_COUNT_EN
      chk("wr_count_three", wr_count, 32'd3);
`endif
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
